tw4_mul_stage: RTL and testbench

Twiddle-multiply stage of the 4-point FFT datapath. It sits directly downstream of the 4-entry twiddle ROM (mem_tw4) and the preceding butterfly. It consumes the butterfly output stream, drives the ROM address, and multiplies each sample by the ROM's complex twiddle (10-bit, 8 fractional bits, 1.0 = 256). Products are rounded and saturated before being passed to the next butterfly stage through a 2-cycle valid pipeline.

---
 rtl/tw4_mul_stage_if.sv | 29 ++
 rtl/tw4_mul_stage.sv | 136 +++++++++++++
 tb/tb_tw4_mul_stage.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tw4_mul_stage_if.sv
// Stream and twiddle-ROM bundle for the 4-point FFT twiddle-multiply stage.
// The slave side is the multiply stage. The master side is its environment:
// the upstream butterfly, the twiddle ROM and the downstream butterfly.
interface tw4_mul_stage_if #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 13,
  parameter int TW_W  = 10
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_re;
  logic signed [IN_W-1:0]  in_im;
  logic [1:0]              tw_addr;
  logic signed [TW_W-1:0]  tw_re;
  logic signed [TW_W-1:0]  tw_im;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_re;
  logic signed [OUT_W-1:0] out_im;
  logic                    out_last;

  modport master (
    output in_valid, in_re, in_im, tw_re, tw_im,
    input  tw_addr, out_valid, out_re, out_im, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, tw_re, tw_im,
    output tw_addr, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/tw4_mul_stage.sv
// Twiddle-multiply stage of the 4-point FFT.
// This block drives the twiddle ROM address and multiplies each incoming
// sample by the returned complex twiddle. The twiddle is a Q1.8 value, so
// 256 represents 1.0. Each product is rounded half toward +inf, saturated to
// OUT_W, and delivered two clocks after the sample is accepted.
module tw4_mul_stage #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 13,
  parameter int TW_W  = 10,
  parameter int REP   = 1
) (
  input logic           clk,
  input logic           rstn,
  input logic           clr,
  tw4_mul_stage_if.slave bus
);

  localparam int REP_W  = 4;
  localparam int PROD_W = IN_W + TW_W + 1;
  localparam int RND_W  = PROD_W + 1;
  localparam int SHR_W  = RND_W - 8;
  localparam logic [REP_W-1:0]        REP_LAST = REP_W'(REP - 1);
  localparam logic signed [SHR_W-1:0] SAT_MAX  = SHR_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SHR_W-1:0] SAT_MIN  = SHR_W'(-(2 ** (OUT_W - 1)));

  logic [1:0]              twAddr_q;
  logic [REP_W-1:0]        repCnt_q;
  logic                    accept;
  logic                    frameEnd;

  logic signed [IN_W-1:0]  aRe_q, aIm_q;
  logic signed [TW_W-1:0]  wRe_q, wIm_q;
  logic                    v1_q, last1_q;

  logic signed [PROD_W-1:0] aReX, aImX, wReX, wImX;
  logic signed [PROD_W-1:0] pRe, pIm;
  logic signed [RND_W-1:0]  rRe, rIm;
  logic signed [SHR_W-1:0]  shRe, shIm;
  logic signed [OUT_W-1:0]  outRe_d, outIm_d;

  logic                    outValid_q, outLast_q;
  logic signed [OUT_W-1:0] outRe_q, outIm_q;

  // Clamp a rounded product into the OUT_W two's-complement range.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [SHR_W-1:0] v);
    if (v > SAT_MAX) begin
      saturate = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      saturate = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      saturate = OUT_W'(v);
    end
  endfunction

  assign accept      = bus.in_valid && !clr;
  assign frameEnd    = (twAddr_q == 2'd3) && (repCnt_q == REP_LAST);
  assign bus.tw_addr = twAddr_q;

  // Frame position: every accepted sample bumps the repeat count, and the address advances once REP samples have shared it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      twAddr_q <= 2'd0;
      repCnt_q <= '0;
    end else if (clr) begin
      twAddr_q <= 2'd0;
      repCnt_q <= '0;
    end else if (bus.in_valid) begin
      if (repCnt_q == REP_LAST) begin
        repCnt_q <= '0;
        twAddr_q <= twAddr_q + 2'd1;
      end else begin
        repCnt_q <= repCnt_q + 1'b1;
      end
    end
  end

  // Stage 1: capture the sample together with the twiddle the ROM returns for the current address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aRe_q   <= '0;
      aIm_q   <= '0;
      wRe_q   <= '0;
      wIm_q   <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        aRe_q   <= bus.in_re;
        aIm_q   <= bus.in_im;
        wRe_q   <= bus.tw_re;
        wIm_q   <= bus.tw_im;
        last1_q <= frameEnd;
      end
    end
  end

  // Complex multiply at full width, then round half up and saturate.
  always_comb begin
    aReX    = PROD_W'(aRe_q);
    aImX    = PROD_W'(aIm_q);
    wReX    = PROD_W'(wRe_q);
    wImX    = PROD_W'(wIm_q);
    pRe     = aReX * wReX - aImX * wImX;
    pIm     = aReX * wImX + aImX * wReX;
    rRe     = RND_W'(pRe) + RND_W'(128);
    rIm     = RND_W'(pIm) + RND_W'(128);
    shRe    = SHR_W'(rRe >>> 8);
    shIm    = SHR_W'(rIm >>> 8);
    outRe_d = saturate(shRe);
    outIm_d = saturate(shIm);
  end

  // Stage 2: register the result. The data holds its value while no sample is flowing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outValid_q <= 1'b0;
      outRe_q    <= '0;
      outIm_q    <= '0;
      outLast_q  <= 1'b0;
    end else begin
      outValid_q <= v1_q && !clr;
      if (v1_q) begin
        outRe_q   <= outRe_d;
        outIm_q   <= outIm_d;
        outLast_q <= last1_q;
      end
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_re    = outRe_q;
  assign bus.out_im    = outIm_q;
  assign bus.out_last  = outLast_q;

endmodule

// File: tb/tb_tw4_mul_stage.sv
// Testbench for tw4_mul_stage.
// Two instances run side by side: one with REP=1 and one with REP=2. Both see
// the same stimulus, and both read the same twiddle table, each at its own
// address. A scoreboard queue for each instance is filled with model results
// when a sample is issued. Monitors pop those results and compare them.
module tb_tw4_mul_stage;

  typedef struct {
    int re;
    int im;
    int last;
    int issue;
  } exp_t;

  logic clk;
  logic rstn;
  logic clr;
  logic inValid;
  logic signed [12:0] inRe;
  logic signed [12:0] inIm;

  int romRe[4];
  int romIm[4];
  int repOf[2] = '{1, 2};
  int accCnt[2];
  exp_t expQ[2][$];
  int cyc;
  int checks;
  int errors;

  tw4_mul_stage_if bus1 ();
  tw4_mul_stage_if bus2 ();

  tw4_mul_stage #(.IN_W(13), .OUT_W(13), .TW_W(10), .REP(1)) dut1 (
    .clk(clk), .rstn(rstn), .clr(clr), .bus(bus1)
  );
  tw4_mul_stage #(.IN_W(13), .OUT_W(13), .TW_W(10), .REP(2)) dut2 (
    .clk(clk), .rstn(rstn), .clr(clr), .bus(bus2)
  );

  // The twiddle ROM stub is combinational in the address, like mem_tw4.
  assign bus1.in_valid = inValid;
  assign bus1.in_re    = inRe;
  assign bus1.in_im    = inIm;
  assign bus1.tw_re    = 10'(romRe[bus1.tw_addr]);
  assign bus1.tw_im    = 10'(romIm[bus1.tw_addr]);
  assign bus2.in_valid = inValid;
  assign bus2.in_re    = inRe;
  assign bus2.in_im    = inIm;
  assign bus2.tw_re    = 10'(romRe[bus2.tw_addr]);
  assign bus2.tw_im    = 10'(romIm[bus2.tw_addr]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so that each scoreboard entry knows when its output is due.
  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round half toward +inf, then clamp to 13-bit signed.
  function automatic int roundSat(input int p);
    int q;
    q = (p + 128) >>> 8;
    if (q > 4095) q = 4095;
    if (q < -4096) q = -4096;
    return q;
  endfunction

  function automatic int dutAddr(input int d);
    return (d == 0) ? int'(bus1.tw_addr) : int'(bus2.tw_addr);
  endfunction

  // Drive one cycle of stimulus and update the reference model for both instances.
  task automatic applyStimulus(input bit v, input int re, input int im, input bit c);
    int addr;
    exp_t e;
    inValid = v;
    inRe    = 13'(re);
    inIm    = 13'(im);
    clr     = c;
    for (int d = 0; d < 2; d++) begin
      if (c) begin
        while (expQ[d].size() > 0 && expQ[d][expQ[d].size()-1].issue == cyc) begin
          void'(expQ[d].pop_back());
        end
        accCnt[d] = 0;
      end else if (v) begin
        addr = (accCnt[d] / repOf[d]) % 4;
        checkOutput($sformatf("tw_addr[rep%0d]", repOf[d]), dutAddr(d), addr);
        e.re    = roundSat(int'(inRe) * romRe[addr] - int'(inIm) * romIm[addr]);
        e.im    = roundSat(int'(inRe) * romIm[addr] + int'(inIm) * romRe[addr]);
        e.last  = ((accCnt[d] % (4 * repOf[d])) == 4 * repOf[d] - 1) ? 1 : 0;
        e.issue = cyc + 1;
        expQ[d].push_back(e);
        accCnt[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert the asynchronous reset in the middle of a cycle and check that the state clears immediately.
  task automatic pulseReset();
    inValid = 1'b0;
    clr     = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("rst tw_addr[rep1]", int'(bus1.tw_addr), 0);
    checkOutput("rst tw_addr[rep2]", int'(bus2.tw_addr), 0);
    checkOutput("rst out_valid", int'(bus1.out_valid) + int'(bus2.out_valid), 0);
    checkOutput("rst out_re", int'(bus1.out_re), 0);
    checkOutput("rst out_im", int'(bus1.out_im), 0);
    checkOutput("rst out_last", int'(bus1.out_last) + int'(bus2.out_last), 0);
    for (int d = 0; d < 2; d++) begin
      expQ[d].delete();
      accCnt[d] = 0;
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Scoreboard comparison for one instance, run at each falling edge.
  task automatic monitorStep(input int d, input logic v, input int re, input int im, input int last);
    exp_t e;
    if (!rstn) return;
    while (expQ[d].size() > 0 && expQ[d][0].issue + 1 < cyc) begin
      e = expQ[d].pop_front();
      checkOutput($sformatf("missing out_valid[rep%0d] issue", repOf[d]), cyc, e.issue + 1);
    end
    if (v) begin
      if (expQ[d].size() == 0) begin
        checkOutput($sformatf("unexpected out_valid[rep%0d]", repOf[d]), 1, 0);
      end else begin
        e = expQ[d].pop_front();
        checkOutput($sformatf("latency[rep%0d]", repOf[d]), cyc, e.issue + 1);
        checkOutput($sformatf("out_re[rep%0d]", repOf[d]), re, e.re);
        checkOutput($sformatf("out_im[rep%0d]", repOf[d]), im, e.im);
        checkOutput($sformatf("out_last[rep%0d]", repOf[d]), last, e.last);
      end
    end
  endtask

  always @(negedge clk) monitorStep(0, bus1.out_valid, int'(bus1.out_re), int'(bus1.out_im), int'(bus1.out_last));
  always @(negedge clk) monitorStep(1, bus2.out_valid, int'(bus2.out_re), int'(bus2.out_im), int'(bus2.out_last));

  task automatic setRom(input int r0, input int i0, input int r1, input int i1,
                        input int r2, input int i2, input int r3, input int i3);
    romRe = '{r0, r1, r2, r3};
    romIm = '{i0, i1, i2, i3};
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int pattern[7] = '{1, 0, 0, 1, 1, 0, 1};
    checks  = 0;
    errors  = 0;
    rstn    = 1'b0;
    clr     = 1'b0;
    inValid = 1'b0;
    inRe    = '0;
    inIm    = '0;
    accCnt  = '{0, 0};
    setRom(256, 0, 256, 0, 256, 0, 0, -256);
    @(posedge clk);
    #1;
    checkOutput("reset tw_addr", int'(bus1.tw_addr), 0);
    checkOutput("reset out_valid", int'(bus1.out_valid), 0);
    checkOutput("reset out_re", int'(bus1.out_re), 0);
    checkOutput("reset out_im", int'(bus1.out_im), 0);
    checkOutput("reset out_last", int'(bus1.out_last), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    $display("[TB] frame of eight (100,50) samples with the standard table");
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 100, 50, 1'b0);
    idle(3);

    $display("[TB] rounding cases");
    setRom(0, -256, 0, -256, 0, -256, 0, -256);
    applyStimulus(1'b1, -3, 7, 1'b0);
    setRom(128, 0, 128, 0, 128, 0, 128, 0);
    applyStimulus(1'b1, 3, -3, 1'b0);
    idle(3);

    $display("[TB] saturation cases");
    setRom(0, -256, 0, -256, 0, -256, 0, -256);
    applyStimulus(1'b1, -4096, 0, 1'b0);
    applyStimulus(1'b1, 0, -4096, 1'b0);
    setRom(-512, -512, -512, -512, -512, -512, -512, -512);
    applyStimulus(1'b1, -4096, -4096, 1'b0);
    applyStimulus(1'b1, 4095, -4096, 1'b0);
    idle(3);

    $display("[TB] gapped input");
    setRom(256, 0, 256, 0, 256, 0, 0, -256);
    for (int k = 0; k < 7; k++) applyStimulus(pattern[k] != 0, 10 * k + 1, -7 * k, 1'b0);
    idle(3);

    $display("[TB] clear then reset mid-stream");
    applyStimulus(1'b1, 300, -200, 1'b0);
    applyStimulus(1'b1, -150, 75, 1'b0);
    applyStimulus(1'b1, 999, 999, 1'b1);
    applyStimulus(1'b1, 40, 20, 1'b0);
    applyStimulus(1'b1, 41, 21, 1'b0);
    pulseReset();
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 60 + k, -30, 1'b0);
    idle(3);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 1500; k++) begin
      if (k % 16 == 0) begin
        for (int a = 0; a < 4; a++) begin
          romRe[a] = int'($urandom_range(0, 1023)) - 512;
          romIm[a] = int'($urandom_range(0, 1023)) - 512;
        end
      end
      if (k == 777) pulseReset();
      applyStimulus($urandom_range(0, 99) < 75,
                    int'($urandom_range(0, 8191)) - 4096,
                    int'($urandom_range(0, 8191)) - 4096,
                    $urandom_range(0, 99) < 3);
    end
    idle(5);

    checkOutput("drained scoreboard[rep1]", expQ[0].size(), 0);
    checkOutput("drained scoreboard[rep2]", expQ[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
